// File: rtl/mux16_scan_serializer.sv
// Drives a 16:1 mux with a loaded word, walks its select, and serializes the sampled output.
// Each sampled bit is checked against the loaded word; mismatches latch a sticky err flag.
module mux16_scan_serializer #(
  parameter int SETTLE_CYCLES = 1,
  parameter bit SCAN_DESC     = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [0:15] load_data,
  output logic [0:15] mux_in,
  output logic [0:3]  mux_sel,
  input  logic        mux_out,
  output logic        ser_valid,
  input  logic        ser_ready,
  output logic        ser_data,
  output logic [0:3]  ser_index,
  output logic        ser_last,
  output logic        busy,
  output logic        err,
  input  logic        err_clr
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] PRESENT = 2'd2;

  localparam logic [0:3] SEL_START = SCAN_DESC ? 4'd15 : 4'd0;
  localparam logic [0:3] SEL_END   = SCAN_DESC ? 4'd0 : 4'd15;
  localparam logic [3:0] CNT_LOAD  = 4'(SETTLE_CYCLES);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       sample;
  logic       mismatch;

  // cnt == 1 marks the final settle cycle: the edge that ends it captures mux_out.
  assign sample   = (state == SETTLE) && (cnt == 4'd1);
  assign mismatch = sample && (mux_out != mux_in[mux_sel]);

  assign load_ready = (state == IDLE);
  assign ser_valid  = (state == PRESENT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      mux_in    <= '0;
      mux_sel   <= SEL_START;
      ser_data  <= 1'b0;
      ser_index <= '0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            mux_in  <= load_data;
            mux_sel <= SEL_START;
            cnt     <= CNT_LOAD;
            busy    <= 1'b1;
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt - 4'd1;
          if (sample) begin
            ser_data  <= mux_out;
            ser_index <= mux_sel;
            ser_last  <= (mux_sel == SEL_END);
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (ser_ready) begin
            if (ser_last) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              mux_sel <= SCAN_DESC ? mux_sel - 4'd1 : mux_sel + 4'd1;
              cnt     <= CNT_LOAD;
              state   <= SETTLE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // A fresh mismatch outranks a clear arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (mismatch) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux16_scan_serializer.sv
// Bench for mux16_scan_serializer: three instances (ascending S=1, descending S=1, ascending S=3),
// each checked every cycle against a transaction-level model, plus directed literal checks.
module tb_mux16_scan_serializer;

  logic clk;
  logic rst_n;

  logic        ld_v   [3];
  logic        ld_r   [3];
  logic [0:15] ld_d   [3];
  logic [0:15] mx_in  [3];
  logic [0:3]  mx_sel [3];
  logic        mx_out [3];
  logic        s_v    [3];
  logic        s_r    [3];
  logic        s_d    [3];
  logic [0:3]  s_idx  [3];
  logic        s_last [3];
  logic        bsy    [3];
  logic        er     [3];
  logic        eclr   [3];
  logic        stuck  [3];

  int n_chk;
  int n_fail;

  const int S [3] = '{1, 1, 3};
  const bit D [3] = '{1'b0, 1'b1, 1'b0};

  // Behavioural 16:1 mux with an optional stuck-at-0 fault on its output.
  assign mx_out[0] = stuck[0] ? 1'b0 : mx_in[0][mx_sel[0]];
  assign mx_out[1] = stuck[1] ? 1'b0 : mx_in[1][mx_sel[1]];
  assign mx_out[2] = stuck[2] ? 1'b0 : mx_in[2][mx_sel[2]];

  mux16_scan_serializer #(.SETTLE_CYCLES(1), .SCAN_DESC(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .load_valid(ld_v[0]), .load_ready(ld_r[0]), .load_data(ld_d[0]),
    .mux_in(mx_in[0]), .mux_sel(mx_sel[0]), .mux_out(mx_out[0]), .ser_valid(s_v[0]),
    .ser_ready(s_r[0]), .ser_data(s_d[0]), .ser_index(s_idx[0]), .ser_last(s_last[0]),
    .busy(bsy[0]), .err(er[0]), .err_clr(eclr[0]));

  mux16_scan_serializer #(.SETTLE_CYCLES(1), .SCAN_DESC(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .load_valid(ld_v[1]), .load_ready(ld_r[1]), .load_data(ld_d[1]),
    .mux_in(mx_in[1]), .mux_sel(mx_sel[1]), .mux_out(mx_out[1]), .ser_valid(s_v[1]),
    .ser_ready(s_r[1]), .ser_data(s_d[1]), .ser_index(s_idx[1]), .ser_last(s_last[1]),
    .busy(bsy[1]), .err(er[1]), .err_clr(eclr[1]));

  mux16_scan_serializer #(.SETTLE_CYCLES(3), .SCAN_DESC(1'b0)) u2 (
    .clk(clk), .rst_n(rst_n), .load_valid(ld_v[2]), .load_ready(ld_r[2]), .load_data(ld_d[2]),
    .mux_in(mx_in[2]), .mux_sel(mx_sel[2]), .mux_out(mx_out[2]), .ser_valid(s_v[2]),
    .ser_ready(s_r[2]), .ser_data(s_d[2]), .ser_index(s_idx[2]), .ser_last(s_last[2]),
    .busy(bsy[2]), .err(er[2]), .err_clr(eclr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: a word in flight is just (word, bits handed off, settle cycles left).
  bit          m_act  [3];
  bit          m_err  [3];
  logic [0:15] m_word [3];
  int          m_pos  [3];
  int          m_wait [3];
  int          m_sel  [3];

  function automatic int scan_idx(input int i, input int pos);
    return D[i] ? 15 - pos : pos;
  endfunction

  always @(negedge clk) begin : model_cmp
    int   k;
    logic eb;
    bit   mism;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_act[i]  = 1'b0;
        m_err[i]  = 1'b0;
        m_word[i] = '0;
        m_pos[i]  = 0;
        m_wait[i] = 0;
        m_sel[i]  = D[i] ? 15 : 0;
        chk($sformatf("rst_busy%0d", i), bsy[i], 0);
        chk($sformatf("rst_valid%0d", i), s_v[i], 0);
        chk($sformatf("rst_mux_in%0d", i), mx_in[i], 0);
        chk($sformatf("rst_err%0d", i), er[i], 0);
        chk($sformatf("rst_sel%0d", i), mx_sel[i], m_sel[i]);
      end else begin
        k = scan_idx(i, m_pos[i]);
        chk($sformatf("busy%0d", i), bsy[i], m_act[i]);
        chk($sformatf("load_ready%0d", i), ld_r[i], !m_act[i]);
        chk($sformatf("ser_valid%0d", i), s_v[i], m_act[i] && m_wait[i] == 0);
        chk($sformatf("err%0d", i), er[i], m_err[i]);
        chk($sformatf("mux_in%0d", i), mx_in[i], m_word[i]);
        chk($sformatf("mux_sel%0d", i), mx_sel[i], m_sel[i]);
        if (m_act[i] && m_wait[i] == 0) begin
          eb = stuck[i] ? 1'b0 : m_word[i][k];
          chk($sformatf("ser_data%0d", i), s_d[i], eb);
          chk($sformatf("ser_index%0d", i), s_idx[i], k);
          chk($sformatf("ser_last%0d", i), s_last[i], m_pos[i] == 15);
        end
        mism = m_act[i] && m_wait[i] == 1 && stuck[i] && m_word[i][k];
        if (mism) m_err[i] = 1'b1;
        else if (eclr[i]) m_err[i] = 1'b0;
        if (m_act[i]) begin
          if (m_wait[i] > 0) begin
            m_wait[i]--;
          end else if (s_r[i]) begin
            if (m_pos[i] == 15) begin
              m_act[i] = 1'b0;
            end else begin
              m_pos[i]++;
              m_wait[i] = S[i];
              m_sel[i]  = scan_idx(i, m_pos[i]);
            end
          end
        end else if (ld_v[i]) begin
          m_act[i]  = 1'b1;
          m_word[i] = ld_d[i];
          m_pos[i]  = 0;
          m_wait[i] = S[i];
          m_sel[i]  = scan_idx(i, 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input logic [0:15] w);
    int n;
    ld_d[i] = w;
    ld_v[i] = 1'b1;
    n = 0;
    while (!ld_r[i] && n < 50) begin
      tick();
      n++;
    end
    chk("load_accept_bound", n < 50, 1);
    tick();
    ld_v[i] = 1'b0;
  endtask

  task automatic run_word(input int i, input logic [0:15] w, input bit toggle,
                          output logic [0:15] got, output int cycles, output int lat,
                          output int first_idx, output int last_idx, output int nbits);
    int cyc;
    load(i, w);
    got = '0; lat = -1; first_idx = -1; last_idx = -1; nbits = 0; cyc = 0;
    while (bsy[i] && cyc < 600) begin
      s_r[i] = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (s_v[i] && lat < 0) lat = cyc;
      if (s_v[i] && s_r[i]) begin
        got[s_idx[i]] = s_d[i];
        if (nbits == 0) first_idx = int'(s_idx[i]);
        if (s_last[i]) last_idx = int'(s_idx[i]);
        nbits++;
      end
      tick();
      cyc++;
    end
    chk("word_done_bound", cyc < 600, 1);
    cycles = cyc;
    s_r[i] = 1'b1;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [0:15] got;
    int cycles, lat, fidx, lidx, nb, n;
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 3; i++) begin
      ld_v[i] = 1'b0; ld_d[i] = '0; s_r[i] = 1'b1; eclr[i] = 1'b0; stuck[i] = 1'b0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_sel_desc", mx_sel[1], 15);
    chk("reset_busy", bsy[0], 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", ld_r[0], 1);

    // Single 1 at index 0, ascending, ready always high.
    run_word(0, 16'b1000000000000000, 1'b0, got, cycles, lat, fidx, lidx, nb);
    chk("t1_word", got, 16'h8000);
    chk("t1_cycles", cycles, 32);
    chk("t1_latency", lat, 1);
    chk("t1_first_idx", fidx, 0);
    chk("t1_last_idx", lidx, 15);
    chk("t1_nbits", nb, 16);
    chk("t1_err", er[0], 0);

    // Back-pressure pattern 1,0,0,1.
    run_word(0, 16'hA5C3, 1'b1, got, cycles, lat, fidx, lidx, nb);
    chk("t2_word", got, 16'hA5C3);
    chk("t2_nbits", nb, 16);

    // Descending scan.
    run_word(1, 16'b0000000000000001, 1'b0, got, cycles, lat, fidx, lidx, nb);
    chk("t3_word", got, 16'h0001);
    chk("t3_first_idx", fidx, 15);
    chk("t3_last_idx", lidx, 0);

    // Stuck-at-0 mux output with all-ones word.
    stuck[0] = 1'b1;
    s_r[0] = 1'b0;
    load(0, 16'hFFFF);
    eclr[0] = 1'b1;
    tick();
    eclr[0] = 1'b0;
    chk("t4_set_wins", er[0], 1);
    eclr[0] = 1'b1;
    tick();
    eclr[0] = 1'b0;
    chk("t4_clear", er[0], 0);
    s_r[0] = 1'b1;
    n = 0;
    while (bsy[0] && n < 100) begin tick(); n++; end
    chk("t4_done_bound", n < 100, 1);
    chk("t4_sticky", er[0], 1);
    stuck[0] = 1'b0;
    eclr[0] = 1'b1;
    tick();
    eclr[0] = 1'b0;
    chk("t4_idle_clear", er[0], 0);

    // Load while busy is ignored, then reset mid-scan at bit 7.
    load(0, 16'h1234);
    ld_d[0] = 16'hFFFF;
    ld_v[0] = 1'b1;
    chk("t5_busy_not_ready", ld_r[0], 0);
    repeat (4) tick();
    ld_v[0] = 1'b0;
    n = 0;
    while (!(s_v[0] && s_idx[0] == 4'd7) && n < 100) begin tick(); n++; end
    chk("t5_reach_bit7", n < 100, 1);
    chk("t5_word_kept", mx_in[0], 16'h1234);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", s_v[0], 0);
    chk("t5_rst_mux_in", mx_in[0], 0);
    chk("t5_rst_busy", bsy[0], 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_word(0, 16'h0001, 1'b0, got, cycles, lat, fidx, lidx, nb);
    chk("t5_word", got, 16'h0001);
    chk("t5_first_idx", fidx, 0);

    // Longer settle time.
    run_word(2, 16'h5A0F, 1'b0, got, cycles, lat, fidx, lidx, nb);
    chk("t6_latency", lat, 3);
    chk("t6_cycles", cycles, 64);
    chk("t6_word", got, 16'h5A0F);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux16_scan_serializer.md
Name: mux16_scan_serializer

Overview:
- Upstream driver and consumer for the 16:1 gate-level mux (mux16tol).
- Accepts a 16-bit word over a valid/ready handshake and drives it onto the mux data inputs.
- Steps the mux select through all 16 positions, samples the mux output at each position, and emits the bits as a serial stream with its own valid/ready handshake.
- Compares each sampled bit against the registered word and flags any mismatch, so the mux is self-checked in place.

Parameters:
- SETTLE_CYCLES, 1, cycles the select is held before mux_out is sampled; legal range 1..15.
- SCAN_DESC, 0, scan order: 0 visits sel 0→15, 1 visits sel 15→0.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- load_valid  input  1  load_data is valid
- load_ready  output  1  block accepts a word (IDLE only)
- load_data  input  16  word to scan; index [0:15], bit 0 is the first bit scanned when ascending
- mux_in  output  16  registered word to the mux in[0:15]
- mux_sel  output  4  select to the mux sel[0:3]; sel[0] is MSB
- mux_out  input  1  mux output, combinational from mux_in and mux_sel
- ser_valid  output  1  ser_data is valid
- ser_ready  input  1  downstream accepts the bit
- ser_data  output  1  sampled mux bit
- ser_index  output  4  select value that ser_data was sampled at
- ser_last  output  1  current bit is the 16th of the word
- busy  output  1  scan in progress (not IDLE)
- err  output  1  sticky mismatch flag
- err_clr  input  1  synchronous clear of err

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - mux_in = 0; mux_sel = 0 (15 if SCAN_DESC); ser_valid = 0; ser_data = 0; ser_index = 0; ser_last = 0; busy = 0; err = 0.
  - Settle counter = 0.
  - load_ready = 1 one cycle after rst_n deasserts.
  - Reset asserted mid-scan aborts the word; no partial bits are emitted after release.
- States: IDLE, SETTLE, PRESENT.
- IDLE:
  - load_ready = 1; ser_valid = 0.
  - On a clock edge with load_valid=1: mux_in <= load_data; mux_sel <= start value (0 or 15); counter <= SETTLE_CYCLES; next state SETTLE.
- SETTLE:
  - load_ready = 0; ser_valid = 0.
  - Counter decrements each cycle; the state lasts exactly SETTLE_CYCLES cycles.
  - On the edge leaving SETTLE:
    - ser_data <= mux_out; ser_index <= mux_sel; ser_last <= (mux_sel == end value).
    - If mux_out != mux_in[mux_sel], err <= 1.
    - Next state PRESENT.
- PRESENT:
  - ser_valid = 1.
  - ser_data, ser_index and ser_last hold stable while ser_ready = 0; there is no timeout.
  - On handshake (ser_valid & ser_ready) with ser_last = 0: mux_sel steps +1 (−1 if SCAN_DESC); counter reloads; next state SETTLE.
  - On handshake with ser_last = 1: next state IDLE; mux_in is held and mux_sel is not advanced.
- Latency and throughput:
  - First ser_valid appears SETTLE_CYCLES cycles after the load-accept edge.
  - With ser_ready held high, throughput is 1 bit per SETTLE_CYCLES+1 cycles.
  - A full word takes 16×(SETTLE_CYCLES+1) cycles, then the block is back in IDLE.
  - The next load is accepted no earlier than the cycle after the last handshake; there is no overlap between words.
- Boundary conditions:
  - load_valid while busy is ignored (load_ready = 0); the word must be re-presented later.
  - mux_sel stays within 0..15 by construction; there is no wrap past the end value.
  - err_clr and a mismatch in the same cycle: set wins, err = 1.
  - err persists across words until err_clr or reset.
  - busy = (state != IDLE).
  - All outputs are registered except load_ready and ser_valid, which decode the state register only (no input-to-output combinational path).

Test Plan:
- Load 16'b1000000000000000, SCAN_DESC=0, ser_ready=1, SETTLE=1 → 16 bits 1,0,0,…,0; ser_index 0..15; ser_last only on index 15; 32 cycles; err=0; busy falls after the last handshake.
- Load 16'hA5C3 with ser_ready toggling 1,0,0,1,… → bit stream equals load_data[0..15] in order; ser_data and ser_index stable during stalls; no bit dropped or repeated.
- SCAN_DESC=1, load 16'b0000000000000001 → first bit 1 at ser_index 15; ser_last at ser_index 0.
- Force mux_out stuck-at-0 while loading 16'hFFFF → err=1 after the first sample and stays 1; assert err_clr on the same cycle as a mismatch → err remains 1; assert err_clr with no mismatch → err=0.
- Assert load_valid with a new word mid-scan → ignored, original stream completes; assert rst_n low at bit 7 → ser_valid=0, mux_in=0, busy=0 immediately; after release, new load of 16'h0001 scans from index 0.
- SETTLE_CYCLES=3 → first ser_valid exactly 3 cycles after the accept edge; full word takes 64 cycles with ser_ready high.
